// File: rtl/dio24_btn_events.sv
// dio24_btn_events: per-button short / long / double-click gesture decoder with sticky W1C event register.
// Optional feature macro: BTN_DOUBLE_EN (double-click detection). Rev 1.0
`default_nettype none

module dio24_btn_events #(
  parameter int NUM_BUTTONS  = 2,
  parameter int TICK_BITS    = 16,
  parameter int CNT_BITS     = 12,
  parameter int LONG_TICKS   = 1500,
  parameter int DCLICK_TICKS = 450
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_BUTTONS-1:0]   btn_status,
  input  logic [3*NUM_BUTTONS-1:0] evt_clr,
  output logic [NUM_BUTTONS-1:0]   evt_short,
  output logic [NUM_BUTTONS-1:0]   evt_long,
  output logic [NUM_BUTTONS-1:0]   evt_double,
  output logic [3*NUM_BUTTONS-1:0] evt_sts,
  output logic [NUM_BUTTONS-1:0]   btn_held
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_e;

  localparam int CNT_SAT_I = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(CNT_SAT_I);
  localparam logic [CNT_BITS-1:0] LONG_CNT = CNT_BITS'(LONG_TICKS);
`ifdef BTN_DOUBLE_EN
  localparam logic [CNT_BITS-1:0] DCLICK_CNT = CNT_BITS'(DCLICK_TICKS);
`endif

  logic [TICK_BITS-1:0]     presc_q, presc_d;
  logic                     tick;
  state_e                   state_q [NUM_BUTTONS];
  state_e                   state_d [NUM_BUTTONS];
  logic [CNT_BITS-1:0]      cnt_q   [NUM_BUTTONS];
  logic [CNT_BITS-1:0]      cnt_d   [NUM_BUTTONS];
  logic [CNT_BITS-1:0]      cnt_inc [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0]   short_q, short_d, long_q, long_d, double_q, double_d, held_q, held_d;
  logic [3*NUM_BUTTONS-1:0] sts_q, sts_d;

  always_comb begin
    presc_d  = presc_q + TICK_BITS'(1);
    tick     = &presc_q;
    short_d  = '0;
    long_d   = '0;
    double_d = '0;
    held_d   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + CNT_BITS'(1);
      // Release is tested before the tick so it wins a same-cycle race.
      case (state_q[i])
        ST_IDLE: begin
          if (btn_status[i]) begin
            state_d[i] = ST_PRESS1;
            cnt_d[i]   = '0;
          end
        end
        ST_PRESS1: begin
          if (!btn_status[i]) begin
`ifdef BTN_DOUBLE_EN
            state_d[i] = ST_WAIT2;
            cnt_d[i]   = '0;
`else
            state_d[i] = ST_IDLE;
            short_d[i] = 1'b1;
`endif
          end else if (tick) begin
            cnt_d[i] = cnt_inc[i];
            if (cnt_inc[i] == LONG_CNT) begin
              state_d[i] = ST_LONG;
              long_d[i]  = 1'b1;
            end
          end
        end
`ifdef BTN_DOUBLE_EN
        ST_WAIT2: begin
          if (btn_status[i]) begin
            state_d[i] = ST_PRESS2;
            cnt_d[i]   = '0;
          end else if (tick) begin
            cnt_d[i] = cnt_inc[i];
            if (cnt_inc[i] == DCLICK_CNT) begin
              state_d[i] = ST_IDLE;
              short_d[i] = 1'b1;
            end
          end
        end
        ST_PRESS2: begin
          if (!btn_status[i]) begin
            state_d[i]  = ST_IDLE;
            double_d[i] = 1'b1;
          end else if (tick) begin
            cnt_d[i] = cnt_inc[i];
            if (cnt_inc[i] == LONG_CNT) begin
              state_d[i] = ST_LONG;
              long_d[i]  = 1'b1;
            end
          end
        end
`endif
        ST_LONG: begin
          if (!btn_status[i]) state_d[i] = ST_IDLE;
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == ST_PRESS1) || (state_d[i] == ST_PRESS2) ||
                  (state_d[i] == ST_LONG);
    end
    // A set spans both the decision cycle and the visible pulse cycle, so a
    // clear written while the pulse is showing cannot lose that event.
    sts_d = (sts_q & ~evt_clr) | {double_d, long_d, short_d} | {double_q, long_q, short_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      short_q  <= '0;
      long_q   <= '0;
      double_q <= '0;
      held_q   <= '0;
      sts_q    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
      sts_q    <= sts_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign evt_short  = short_q;
  assign evt_long   = long_q;
  assign evt_double = double_q;
  assign evt_sts    = sts_q;
  assign btn_held   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_dio24_btn_events.sv
// tb_dio24_btn_events: directed gestures plus random button traffic against a timeline model.
// Honours BTN_DOUBLE_EN the same way as the design. Rev 1.0
`default_nettype none

module tb_dio24_btn_events;

  localparam int NB     = 2;
  localparam int TBITS  = 2;
  localparam int PERIOD = 1 << TBITS;
  localparam int LONG   = 8;
  localparam int DCLK   = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NB-1:0]   btn = '0;
  logic [3*NB-1:0] clr = '0;
  logic [NB-1:0]   evt_short, evt_long, evt_double, btn_held;
  logic [3*NB-1:0] evt_sts;

  dio24_btn_events #(
    .NUM_BUTTONS (NB),
    .TICK_BITS   (TBITS),
    .CNT_BITS    (12),
    .LONG_TICKS  (LONG),
    .DCLICK_TICKS(DCLK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_status(btn),
    .evt_clr   (clr),
    .evt_short (evt_short),
    .evt_long  (evt_long),
    .evt_double(evt_double),
    .evt_sts   (evt_sts),
    .btn_held  (btn_held)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Gesture timeline model: each button is either idle, inside a gesture
  // (counting presses and ticks since its last edge), or spent after a long press.
  int            m_cyc;
  bit            m_active [NB];
  bit            m_down   [NB];
  bit            m_dead   [NB];
  int            m_presses[NB];
  int            m_ticks  [NB];
  logic [NB-1:0] e_short, e_long, e_double, e_held;
  logic [3*NB-1:0] e_sts;

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < NB; i++) begin
      m_active[i] = 0; m_down[i] = 0; m_dead[i] = 0; m_presses[i] = 0; m_ticks[i] = 0;
    end
    e_short = '0; e_long = '0; e_double = '0; e_held = '0; e_sts = '0;
  endtask

  task automatic model_step();
    bit t;
    logic [NB-1:0] ns, nl, nd;
    t = ((m_cyc % PERIOD) == PERIOD - 1);
    m_cyc++;
    ns = '0; nl = '0; nd = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_dead[i]) begin
        if (!btn[i]) m_dead[i] = 0;
      end else if (!m_active[i]) begin
        if (btn[i]) begin
          m_active[i] = 1; m_presses[i] = 1; m_down[i] = 1; m_ticks[i] = 0;
        end
      end else if (m_down[i]) begin
        if (!btn[i]) begin
`ifdef BTN_DOUBLE_EN
          if (m_presses[i] == 2) begin
            nd[i] = 1'b1; m_active[i] = 0;
          end else begin
            m_down[i] = 0; m_ticks[i] = 0;
          end
`else
          ns[i] = 1'b1; m_active[i] = 0;
`endif
        end else if (t) begin
          m_ticks[i]++;
          if (m_ticks[i] == LONG) begin
            nl[i] = 1'b1; m_active[i] = 0; m_dead[i] = 1;
          end
        end
      end else begin
        if (btn[i]) begin
          m_presses[i] = 2; m_down[i] = 1; m_ticks[i] = 0;
        end else if (t) begin
          m_ticks[i]++;
          if (m_ticks[i] == DCLK) begin
            ns[i] = 1'b1; m_active[i] = 0;
          end
        end
      end
      e_held[i] = (m_active[i] && m_down[i]) || m_dead[i];
    end
    e_sts    = (e_sts & ~clr) | {nd, nl, ns} | {e_double, e_long, e_short};
    e_short  = ns;
    e_long   = nl;
    e_double = nd;
  endtask

  task automatic step(input logic [NB-1:0] b, input logic [3*NB-1:0] c);
    btn = b;
    clr = c;
    @(posedge clk);
    model_step();
    #1;
    check_eq("evt_short",  evt_short,  e_short);
    check_eq("evt_long",   evt_long,   e_long);
    check_eq("evt_double", evt_double, e_double);
    check_eq("evt_sts",    evt_sts,    e_sts);
    check_eq("btn_held",   btn_held,   e_held);
  endtask

  initial begin
    bit            seen;
    int            runlen[NB];
    logic [NB-1:0] lvl;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_short",  evt_short,  '0);
    check_eq("rst_long",   evt_long,   '0);
    check_eq("rst_double", evt_double, '0);
    check_eq("rst_sts",    evt_sts,    '0);
    check_eq("rst_held",   btn_held,   '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Short press with a clear racing the pulse, then a lone clear.
    repeat (10) step(2'b01, '0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(2'b00, '0);
      if (evt_short[0]) seen = 1;
    end
    check_eq("short_seen", 32'(seen), 32'd1);
    step(2'b00, 6'b000001);
    check_eq("clr_race_sts0", 32'(evt_sts[0]), 32'd1);
    step(2'b00, 6'b000001);
    check_eq("clr_alone_sts0", 32'(evt_sts[0]), 32'd0);

    // Long press on button 1.
    repeat (60) step(2'b10, '0);
    repeat (10) step(2'b00, '0);
    check_eq("long_sts3", 32'(evt_sts[3]), 32'd1);

    // Double click on button 0.
    step(2'b00, '1);
    repeat (6) step(2'b01, '0);
    repeat (6) step(2'b00, '0);
    repeat (6) step(2'b01, '0);
    repeat (25) step(2'b00, '0);
`ifdef BTN_DOUBLE_EN
    check_eq("dbl_sts4",   32'(evt_sts[4]), 32'd1);
    check_eq("dbl_sts0",   32'(evt_sts[0]), 32'd0);
`else
    check_eq("dbl_sts4",   32'(evt_sts[4]), 32'd0);
    check_eq("dbl_sts0",   32'(evt_sts[0]), 32'd1);
`endif

    // Reset in the middle of a first press.
    step(2'b00, '1);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step(2'b01, '0);
      if (m_active[0] && m_down[0] && m_presses[0] == 1 && m_ticks[0] == 5) seen = 1;
    end
    check_eq("reach_cnt5", 32'(seen), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_short",  evt_short,  '0);
    check_eq("midrst_long",   evt_long,   '0);
    check_eq("midrst_double", evt_double, '0);
    check_eq("midrst_sts",    evt_sts,    '0);
    check_eq("midrst_held",   btn_held,   '0);
    btn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (40) step(2'b00, '0);
    check_eq("midrst_no_evt", evt_sts, '0);

    // Random traffic on both buttons with occasional random clears.
    lvl = '0;
    for (int i = 0; i < NB; i++) runlen[i] = $urandom_range(1, 10);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NB; i++) begin
        if (runlen[i] == 0) begin
          lvl[i] = ~lvl[i];
          case ($urandom_range(0, 3))
            0:       runlen[i] = $urandom_range(1, 6);
            1:       runlen[i] = $urandom_range(7, 20);
            2:       runlen[i] = $urandom_range(25, 50);
            default: runlen[i] = $urandom_range(1, 3);
          endcase
        end
        runlen[i]--;
      end
      step(lvl, ($urandom_range(0, 5) == 0) ? 6'($urandom) : '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
